// File: rtl/if_id_queue.sv
// if_id_queue: small circular buffer decoupling instruction fetch (IF) from
// decode (ID). Fetch pushes {pc, inst} pairs; decode sees the head entry, or
// an all-zero bubble when the queue is empty. Either flush input empties the
// queue at the next edge.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              branch_flush,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              any_flush;
  logic              push;
  logic              pop;

  // Ready and handshake qualifiers. if_ready is taken from cnt alone so it
  // never depends combinationally on stall, flush or if_valid.
  always_comb begin
    any_flush = flush | branch_flush;
    if_ready  = (cnt < CNT_W'(DEPTH));
    push      = if_valid & if_ready & ~stall[1] & ~any_flush;
    pop       = (cnt != '0) & ~stall[2] & ~any_flush;
  end

  // Pointer and occupancy registers; reset, then flush, take priority.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    if (rst || any_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; cnt=0 already masks stale
    // entries on the outputs, and leaving it out keeps the array as plain RAM.
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  // Decode-side view: head entry when occupied, zero bubble otherwise.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    id_valid = (cnt != '0);
    id_pc    = '0;
    id_inst  = '0;
    if (id_valid) begin
      id_pc   = pc_mem[rd_ptr];
      id_inst = inst_mem[rd_ptr];
    end
    count = cnt;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-002 The block SHALL have parameter INST_W, default 32, instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two, 2..16.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port stall  input  6  pipeline stall vector; bit1 = IF stop, bit2 = ID stop, 1 = Stop.
REQ-007 The block SHALL have port flush  input  1  exception flush, discard all contents.
REQ-008 The block SHALL have port branch_flush  input  1  branch mispredict flush, discard all contents.
REQ-009 The block SHALL have port if_valid  input  1  fetch offers if_pc/if_inst this cycle.
REQ-010 The block SHALL have port if_pc  input  ADDR_W  fetched instruction address.
REQ-011 The block SHALL have port if_inst  input  INST_W  fetched instruction word.
REQ-012 The block SHALL have port if_ready  output  1  queue can accept an entry this cycle.
REQ-013 The block SHALL have port id_valid  output  1  id_pc/id_inst hold a real instruction.
REQ-014 The block SHALL have port id_pc  output  ADDR_W  head entry address, zero when empty.
REQ-015 The block SHALL have port id_inst  output  INST_W  head entry instruction, zero (nop bubble) when empty.
REQ-016 The block SHALL have port count  output  clog2(DEPTH+1)  current number of valid entries.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH {pc, inst} entries with write pointer, read pointer and count registers; pointers SHALL wrap modulo DEPTH.
REQ-018 if_ready SHALL equal (count < DEPTH), derived from registered state only, with no combinational path from stall, flush or if_valid.
REQ-019 A push SHALL occur when if_valid=1, if_ready=1, stall[1]=0, flush=0 and branch_flush=0; if_valid with stall[1]=1 SHALL be ignored.
REQ-020 A pop SHALL occur when count>0, stall[2]=0, flush=0 and branch_flush=0.
REQ-021 Pushed data SHALL be visible on id_pc/id_inst no earlier than the cycle after the push edge; latency when empty is exactly one cycle.
REQ-022 id_valid SHALL equal (count>0); id_pc/id_inst SHALL be the head entry when id_valid=1 and all-zero otherwise.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when count=DEPTH-1 or count=1.
REQ-024 When full, a pop in the same cycle SHALL NOT permit a push (if_ready is already 0); the push is retried by fetch.
REQ-025 While stall[2]=1 the head entry and id outputs SHALL hold stable; pushes still proceed while not full.
REQ-026 flush or branch_flush SHALL, at the next edge, set count=0 and both pointers to 0; same-cycle push and pop are discarded; flush wins over all stall bits.
REQ-027 Entry storage need not be cleared on flush; outputs SHALL read zero because count=0.
REQ-028 count SHALL never exceed DEPTH nor underflow below 0 under any input combination.

Reset
REQ-029 When rst=1 at a clock edge, count, write pointer and read pointer SHALL become 0, regardless of all other inputs.
REQ-030 Following reset, outputs SHALL be if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries identically to REQ-029; rst has priority over flush, stall and push.

Verification
REQ-032 The bench SHALL cover the following case: reset, then one push of pc=0x100, inst=0x24010001 with stall=0 -> next cycle id_valid=1, id_pc=0x100; cycle after, with no push, id_valid=0 and outputs 0.
REQ-033 The bench SHALL cover the following case: stall[2]=1 and DEPTH=4 consecutive pushes pc=0x0,0x4,0x8,0xC -> count=4, if_ready=0, id_pc holds 0x0; release stall -> pops return 0x0,0x4,0x8,0xC in order.
REQ-034 The bench SHALL cover the following case: count=3, push and pop in the same cycle -> count stays 3, head advances; repeat for 2*DEPTH cycles -> pointer wrap with FIFO order preserved.
REQ-035 The bench SHALL cover the following case: count=2 with branch_flush=1 and if_valid=1 in the same cycle -> next cycle count=0, id_inst=0, and the offered entry is not stored.
REQ-036 The bench SHALL cover the following case: stall[1]=1, stall[2]=0 with if_valid=1 while empty -> no push, id outputs stay zero (bubble) each cycle.
REQ-037 The bench SHALL cover the following case: rst=1 while full with stall[2]=1 -> next cycle count=0, if_ready=1, id_valid=0.
